// File: rtl/mix_column_seq.sv
// mix_column_seq: sequential AES MixColumns / InvMixColumns over one 32-bit
// column, with every GF(2^8) multiply time-shared through a single xtime unit.
// Forward columns spend 4 cycles in CALC; inverse columns first spend 4 cycles
// in PRE, which folds the inverse matrix into a forward one.
// Optional feature: define MIX_INVERSE_EN to honour i_inv and build PRE.
// Without it, i_inv is ignored and every column takes the forward path.
module mix_column_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_col,
  input  logic        i_inv,
  input  logic        i_valid,
  output logic        i_ready,
  output logic [31:0] o_col,
  output logic        o_valid,
  input  logic        o_ready
);

  typedef enum logic [1:0] {IDLE, PRE, CALC, DONE} state_t;

  state_t state_reg, state_next;

  // a_reg[0] holds a0 (i_col[31:24]) ... a_reg[3] holds a3 (i_col[7:0])
  logic [3:0][7:0] a_reg;
  // res_reg[3] is the top byte of o_col, so b_r lands in res_reg[3-r]
  logic [3:0][7:0] res_reg;
  logic [1:0]      step_reg;
  logic            xfer;
  logic [1:0]      r1, r2, r3;
  logic [7:0]      xt_in, xt_out, calc_byte;

`ifdef MIX_INVERSE_EN
  logic [7:0] t_reg;
  logic [7:0] u_reg;
`else
  logic unused_inv;
  assign unused_inv = i_inv;
`endif

  assign xfer = i_valid & i_ready;

  assign r1 = step_reg + 2'd1;
  assign r2 = step_reg + 2'd2;
  assign r3 = step_reg + 2'd3;

  // The one and only xtime unit: shift left, reduce when bit 7 falls out
  assign xt_out = {xt_in[6:0], 1'b0} ^ (xt_in[7] ? POLY : 8'h00);

  // Choose what the shared xtime unit works on this cycle
  always_comb begin
    xt_in = a_reg[step_reg] ^ a_reg[r1];
`ifdef MIX_INVERSE_EN
    if (state_reg == PRE) begin
      case (step_reg)
        2'd0:    xt_in = a_reg[0] ^ a_reg[2];
        2'd2:    xt_in = a_reg[1] ^ a_reg[3];
        default: xt_in = t_reg;
      endcase
    end
`endif
  end

  // b_r = 2*(a_r) ^ 3*(a_r+1) ^ a_r+2 ^ a_r+3, rearranged around one xtime
  assign calc_byte = xt_out ^ a_reg[r1] ^ a_reg[r2] ^ a_reg[r3];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the step counter wraps to 0 on the last step of each phase
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
`ifdef MIX_INVERSE_EN
          state_next = i_inv ? PRE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
`ifdef MIX_INVERSE_EN
      PRE: begin
        if (step_reg == 2'd3) state_next = CALC;
      end
`endif
      CALC: begin
        if (step_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        if (o_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    i_ready = (state_reg == IDLE);
    o_valid = (state_reg == DONE);
  end

  assign o_col = res_reg;

  // Datapath: capture the column, run the pre-pass, then produce b0..b3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      res_reg  <= '0;
      step_reg <= 2'd0;
`ifdef MIX_INVERSE_EN
      t_reg    <= 8'h00;
      u_reg    <= 8'h00;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            for (int i = 0; i < 4; i++) begin
              a_reg[i] <= i_col[31-8*i -: 8];
            end
            step_reg <= 2'd0;
          end
        end
`ifdef MIX_INVERSE_EN
        PRE: begin
          step_reg <= step_reg + 2'd1;
          case (step_reg)
            2'd0: t_reg <= xt_out;
            2'd1: u_reg <= xt_out;
            2'd2: t_reg <= xt_out;
            default: begin
              a_reg[0] <= a_reg[0] ^ u_reg;
              a_reg[2] <= a_reg[2] ^ u_reg;
              a_reg[1] <= a_reg[1] ^ xt_out;
              a_reg[3] <= a_reg[3] ^ xt_out;
            end
          endcase
        end
`endif
        CALC: begin
          res_reg[2'd3 - step_reg] <= calc_byte;
          step_reg                 <= step_reg + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_column_seq.sv
// Bench for mix_column_seq: matrix-based GF(2^8) reference model, a per-cycle
// monitor that checks handshakes, latency and data, directed vectors and a
// randomized run with random output backpressure.
module tb_mix_column_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_col;
  logic        i_inv;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] o_col;
  logic        o_valid;
  logic        o_ready;

`ifdef MIX_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  mix_column_seq dut (
    .clk     (clk),
    .rst     (rst),
    .i_col   (i_col),
    .i_inv   (i_inv),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_col   (o_col),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] x, int n);
    logic [7:0] acc = 8'h00;
    logic [7:0] p   = x;
    for (int b = 0; b < 4; b++) begin
      if (n[b]) acc ^= p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // b_i = sum_j c[(j-i) mod 4] * a_j  (circulant matrix row c0 c1 c2 c3)
  function automatic logic [31:0] mixc(logic [31:0] col, bit inv);
    logic [7:0] a [4];
    logic [7:0] b;
    int c [4];
    logic [31:0] res = 32'h0;
    if (inv) c = '{14, 11, 13, 9};
    else     c = '{2, 3, 1, 1};
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) b ^= gmul(a[j], c[(j - i + 4) % 4]);
      res[31-8*i -: 8] = b;
    end
    return res;
  endfunction

  // ---------------- per-cycle monitor ----------------
  bit          busy     = 1'b0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          exp_lat  = 5;
  bit          exp_v;
  bit          inv_eff;
  logic [31:0] exp_col  = 32'h0;
  logic [31:0] last_out = 32'h0;
  logic [31:0] out_q [$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy     = 1'b0;
      last_out = 32'h0;
      check("rst_o_valid", o_valid, 0);
      check("rst_i_ready", i_ready, 1);
      check("rst_o_col", o_col, 32'h0);
    end else begin
      exp_v = busy && ((cyc - acc_cyc) >= exp_lat);
      check("i_ready", i_ready, !busy);
      check("o_valid_latency", o_valid, exp_v);
      if (exp_v || !busy) check("o_col", o_col, exp_v ? exp_col : last_out);
      if (o_valid && o_ready && exp_v) begin
        busy     = 1'b0;
        last_out = exp_col;
        out_q.push_back(o_col);
        $display("out: col=%h", o_col);
      end else if (i_valid && i_ready && !busy) begin
        busy    = 1'b1;
        acc_cyc = cyc;
        inv_eff = INV_EN && i_inv;
        exp_col = mixc(i_col, inv_eff);
        exp_lat = inv_eff ? 9 : 5;
        $display("in:  col=%h inv=%0d expect=%h", i_col, i_inv, exp_col);
      end
    end
  end

  // ---------------- output backpressure ----------------
  int bp_mode = 0;  // 0: driver controls o_ready, 1: random
  always @(posedge clk) begin
    #1;
    if (bp_mode == 1) o_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] c, input bit inv);
    int k = 0;
    i_col   = c;
    i_inv   = inv;
    i_valid = 1'b1;
    while (!i_ready && k < 60) begin
      tick();
      k++;
    end
    check("send_ready", i_ready, 1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!i_ready && k < 60) begin
      tick();
      k++;
    end
    check("idle_timeout", i_ready, 1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!o_valid && k < 60) begin
      tick();
      k++;
    end
    check("valid_timeout", o_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    i_col   = 32'h0;
    i_inv   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;

    // pin the model to known AES vectors
    check("model_fwd_db", mixc(32'hdb135345, 1'b0), 32'h8e4da1bc);
    check("model_fwd_f2", mixc(32'hf20a225c, 1'b0), 32'h9fdc589d);
    check("model_fwd_c6", mixc(32'hc6c6c6c6, 1'b0), 32'hc6c6c6c6);
    check("model_inv_8e", mixc(32'h8e4da1bc, 1'b1), 32'hdb135345);

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single forward column
    out_q.delete();
    send(32'hdb135345, 1'b0);
    wait_idle();
    check("fwd_db_result", out_q[0], 32'h8e4da1bc);

    // back-to-back columns
    out_q.delete();
    send(32'hf20a225c, 1'b0);
    send(32'h01010101, 1'b0);
    wait_idle();
    check("b2b_count", out_q.size(), 2);
    check("b2b_first", out_q[0], 32'h9fdc589d);
    check("b2b_second", out_q[1], 32'h01010101);

    // inverse request (forward result when the feature is not built)
    out_q.delete();
    send(32'h8e4da1bc, 1'b1);
    wait_idle();
    check("inv_result", out_q[0], INV_EN ? 32'hdb135345 : mixc(32'h8e4da1bc, 1'b0));

    // backpressure: hold o_ready low for 7 cycles after o_valid
    o_ready = 1'b0;
    send(32'hc6c6c6c6, 1'b0);
    wait_valid();
    repeat (7) tick();
    check("bp_hold_col", o_col, 32'hc6c6c6c6);
    check("bp_hold_ready", i_ready, 0);
    o_ready = 1'b1;
    tick();
    check("bp_idle_next", i_ready, 1);
    check("bp_valid_drop", o_valid, 0);
    check("bp_col_kept", o_col, 32'hc6c6c6c6);

    // reset at CALC step 2
    out_q.delete();
    send(32'hdb135345, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_o_valid", o_valid, 0);
    check("rst_mid_o_col", o_col, 32'h0);
    check("rst_mid_i_ready", i_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    send(32'hf20a225c, 1'b0);
    wait_idle();
    check("post_rst_count", out_q.size(), 1);
    check("post_rst_result", out_q[0], 32'h9fdc589d);

    // randomized columns, random inverse flag, random backpressure
    bp_mode = 1;
    for (int n = 0; n < 40; n++) begin
      send($urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
    bp_mode = 0;
    o_ready = 1'b1;
    wait_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
